// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - sequenced per-domain reset release with software re-reset.
// Optional ack timeout enabled by defining RSTSEQ_ACK_TIMEOUT_EN.
module reset_release_sequencer #(
  parameter int N_DOMAINS      = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_sw_rst,
  input  logic [N_DOMAINS-1:0] io_ack,
  output logic [N_DOMAINS-1:0] io_rst_out,
  output logic                 io_done,
  output logic                 io_busy,
  output logic                 io_timeout
);

  localparam int MAX_GH  = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX = (MAX_GH > TIMEOUT_CYCLES) ? MAX_GH : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  typedef enum logic [2:0] {
    S_SYNC,
    S_ACK_WAIT,
    S_GAP,
    S_SW_HOLD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic [2:0]           sync_ff;
  logic                 sync_q;
  logic                 ack_cur;
  logic                 last_dom;

  // Release synchronizer: deassertion of reset reaches sync_q on the 3rd edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_ff <= 3'b000;
    end else begin
      sync_ff <= {sync_ff[1:0], 1'b1};
    end
  end

  assign sync_q = sync_ff[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_SYNC;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
    end
  end

  assign ack_cur  = io_ack[idx_q];
  assign last_dom = (idx_q == IDX_W'(N_DOMAINS - 1));

`ifdef RSTSEQ_ACK_TIMEOUT_EN
  logic tmo_q, tmo_d;
  logic tmo_hit;

  assign tmo_hit = !ack_cur && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Sticky across software re-reset; only the hard reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign io_timeout = tmo_q;
`else
  assign io_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    case (state_q)
      S_SYNC: begin
        if (sync_q) begin
          rst_d[0] = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = S_ACK_WAIT;
        end
      end

      S_ACK_WAIT: begin
        if (io_sw_rst) begin
          rst_d   = '1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SW_HOLD;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
        end else if (ack_cur || tmo_hit) begin
          if (tmo_hit) begin
            tmo_d = 1'b1;
          end
`else
        end else if (ack_cur) begin
`endif
          cnt_d   = '0;
          state_d = last_dom ? S_DONE : S_GAP;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      S_GAP: begin
        if (io_sw_rst) begin
          rst_d   = '1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SW_HOLD;
        end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          idx_d        = idx_q + 1'b1;
          rst_d[idx_d] = 1'b0;
          cnt_d        = '0;
          state_d      = S_ACK_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Hold window restarts whenever the request is (re)asserted.
      S_SW_HOLD: begin
        if (io_sw_rst) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          rst_d[0] = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = S_ACK_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (io_sw_rst) begin
          rst_d   = '1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SW_HOLD;
        end
      end

      default: begin
        rst_d   = '1;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SYNC;
      end
    endcase
  end

  assign io_rst_out = rst_q;
  assign io_done    = (state_q == S_DONE);
  assign io_busy    = (state_q != S_DONE);

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb/tb_reset_release_sequencer.sv - directed checks of release timing, sw re-reset and async reset.
module tb_reset_release_sequencer;

  logic       clock;
  logic       reset;
  logic       io_sw_rst;
  logic [3:0] io_ack;
  logic [3:0] io_rst_out;
  logic       io_done;
  logic       io_busy;
  logic       io_timeout;

  int n_cmp;
  int n_err;
  int edge_n;

  reset_release_sequencer #(
    .N_DOMAINS(4),
    .GAP_CYCLES(8),
    .HOLD_CYCLES(16),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_sw_rst(io_sw_rst),
    .io_ack(io_ack),
    .io_rst_out(io_rst_out),
    .io_done(io_done),
    .io_busy(io_busy),
    .io_timeout(io_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) step();
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rst, input logic done);
    chk({tag, " rst_out"}, 32'(io_rst_out), 32'(rst));
    chk({tag, " done"}, 32'(io_done), 32'(done));
    chk({tag, " busy"}, 32'(io_busy), 32'(!done));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    edge_n    = 0;
    reset     = 1'b1;
    io_sw_rst = 1'b0;
    io_ack    = 4'hF;

    step();
    step();
    chk_all("reset state", 4'hF, 1'b0);
    chk("reset timeout", 32'(io_timeout), 32'h0);

    // Release with all acks high: edges 4, 13, 22, 31, done at 32.
    reset  = 1'b0;
    edge_n = 0;
    step_to(3);
    chk_all("sync edge3", 4'hF, 1'b0);
    step_to(4);
    chk_all("rel0 edge4", 4'hE, 1'b0);
    step_to(12);
    chk_all("gap edge12", 4'hE, 1'b0);
    step_to(13);
    chk_all("rel1 edge13", 4'hC, 1'b0);
    step_to(22);
    chk_all("rel2 edge22", 4'h8, 1'b0);
    step_to(31);
    chk_all("rel3 edge31", 4'h0, 1'b0);
    step_to(32);
    chk_all("done edge32", 4'h0, 1'b1);

    // Software reset from DONE, 5 cycles wide, sampled high at edges 33..37.
    io_sw_rst = 1'b1;
    step_to(33);
    chk_all("sw in done", 4'hF, 1'b0);
    step_to(37);
    io_sw_rst = 1'b0;
    io_ack    = 4'b1101;
    step_to(52);
    chk_all("sw hold edge52", 4'hF, 1'b0);
    step_to(53);
    chk_all("sw rel0 edge53", 4'hE, 1'b0);

    // Ack stall on domain 1 for 50 cycles after its release at edge 62.
    step_to(62);
    chk_all("replay rel1", 4'hC, 1'b0);
    step_to(112);
    chk_all("ack stall", 4'hC, 1'b0);
    io_ack = 4'hF;
    step_to(120);
    chk_all("stall gap edge120", 4'hC, 1'b0);
    step_to(121);
    chk_all("stall rel2 edge121", 4'h8, 1'b0);
    step_to(130);
    chk_all("stall rel3", 4'h0, 1'b0);
    step_to(131);
    chk_all("stall done", 4'h0, 1'b1);

    // Software reset whose sampling edge coincides with the gap expiry at 157.
    io_sw_rst = 1'b1;
    step_to(132);
    io_sw_rst = 1'b0;
    step_to(148);
    chk_all("sw2 rel0", 4'hE, 1'b0);
    step_to(156);
    io_sw_rst = 1'b1;
    step_to(157);
    chk_all("sw on gap expiry", 4'hF, 1'b0);
    io_sw_rst = 1'b0;
    step_to(172);
    chk_all("collide hold edge172", 4'hF, 1'b0);
    step_to(173);
    chk_all("collide rel0 edge173", 4'hE, 1'b0);
    step_to(182);
    chk_all("collide rel1", 4'hC, 1'b0);
    chk("timeout tied low", 32'(io_timeout), 32'h0);

    // Asynchronous reset mid-gap: outputs return without a clock edge.
    step_to(185);
    reset = 1'b1;
    #2;
    chk_all("async reset", 4'hF, 1'b0);
    reset  = 1'b0;
    edge_n = 0;
    step_to(3);
    chk_all("restart sync edge3", 4'hF, 1'b0);
    step_to(4);
    chk_all("restart rel0 edge4", 4'hE, 1'b0);
    step_to(13);
    chk_all("restart rel1 edge13", 4'hC, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
